pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the RV32 pipeline. It tracks destination registers of up to NSTAGES in-flight instructions beyond decode and produces per-operand forward selects. It stalls decode on load-use hazards, squashes decode on a redirect, and keeps a stall-cycle performance counter. It replaces hand-written per-stage bypass compares in the pipeline controller.

Parameters:
NSTAGES, 2, tracked stages after decode; entry 1 = X, entry NSTAGES = oldest (writeback side); legal 1..7
NSRC, 2, source operands per instruction
REG_AW, 5, register address width
LOAD_LAT, 1, a load in entry k cannot forward while k <= LOAD_LAT; must be < NSTAGES
FSEL_W, clog2(NSTAGES+1), forward-select width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
dec_valid  in  1  decode holds a valid instruction
dec_rs  in  NSRC*REG_AW  source register addresses; operand i = bits [i*REG_AW +: REG_AW]
dec_rs_used  in  NSRC  operand i is actually read
dec_rd  in  REG_AW  destination register
dec_we  in  1  instruction writes the regfile
dec_is_load  in  1  instruction is a load
redirect  in  1  taken branch/jump resolved in entry 1 this cycle
perf_clr  in  1  synchronous clear of stall_cycles
stall  out  1  hold PC and decode; insert bubble into entry 1
flush_dec  out  1  squash the decode instruction
fwd_sel  out  NSRC*FSEL_W  per operand: 0 = regfile, k = forward from entry k
stage_valid  out  NSTAGES  valid bit per entry, used to gate write enables
stall_cycles  out  32  saturating count of stall cycles

Behaviour:
- Entry state: each entry k holds valid, we, is_load and rd[REG_AW-1:0].
- Reset (reset=0, asynchronous): all entries cleared, stall_cycles=0. Outputs while in reset: stall=0, flush_dec=0, fwd_sel=0, stage_valid=0. This applies even mid-stream.
- Match rule: operand i matches entry k when all hold: dec_rs_used[i], rs!=0, entry valid, entry we, entry rd==rs.
- Priority: the youngest matching entry (smallest k) wins.
- fwd_sel[i]: k of the winning entry, else 0. Output is combinational from the current table and decode inputs.
- Load-use: the winning entry is a load and k <= LOAD_LAT. Asserts a hazard; fwd_sel[i] still shows k but consumers ignore it while stall=1.
- stall = dec_valid & !redirect & (load-use on any operand).
- flush_dec = redirect. Redirect overrides stall.
- Per-cycle update, all entries at the rising edge of clk:
  - entry 1 <= {dec_valid & !stall & !redirect, dec_we, dec_is_load, dec_rd}; the valid bit is 0 when stall or redirect (bubble).
  - entry k <= entry k-1 for k=2..NSTAGES; the oldest entry drops out.
  - Older entries always advance. A stall only inserts a bubble; it never freezes the table.
- Latency: an instruction appears in entry 1 one cycle after acceptance and in entry k after k cycles.
- Worst case: a load-use stall lasts LOAD_LAT-k+1 cycles, where k is the load's entry position when the dependent instruction first reaches decode. Back-to-back load then use gives LOAD_LAT cycles.
- A writer with dec_rd=0 is tracked but never matches.
- stall_cycles: +1 per cycle with stall=1. Saturates at 32'hFFFFFFFF. perf_clr has priority: clears to 0 that edge, and an increment in the same cycle is dropped.
- No X propagation: when dec_valid=0, stall=0 and entry 1 gets a bubble; fwd_sel is still computed but is don't-care to consumers.

Test Plan:
(Defaults: NSTAGES=2, LOAD_LAT=1.)
1. Forward distance: add x5 (we=1) accepted at cycle 0. A reader with rs1=x5 in decode at cycle 1 -> fwd_sel[0]=1, stall=0. The same reader held at cycle 2 -> 2; at cycle 3 -> 0.
2. Load-use: lw x6 accepted at cycle 0; add x7,x6,x6 in decode at cycle 1 -> stall=1 and stage_valid[0]=0 at cycle 2. At cycle 2 -> stall=0, fwd_sel={2,2}, stall_cycles=1.
3. Youngest wins: writes to x5 accepted at cycles 0 and 1; reader at cycle 2 -> fwd_sel[0]=1. With dec_rs_used[1]=0 and rs2=x5 -> fwd_sel[1]=0.
4. x0 and unused: writer with rd=x0, then a reader with rs1=x0 -> fwd_sel=0, stall=0.
5. Redirect over stall: a load-use condition present and redirect=1 in the same cycle -> stall=0, flush_dec=1, stage_valid[0]=0 next cycle, stall_cycles unchanged.
6. Reset and counter:
   - Drive reset low asynchronously between edges with a full table -> stage_valid=0 immediately, stall_cycles=0.
   - Preload stall_cycles=32'hFFFFFFFF and force a stall -> value stays at 32'hFFFFFFFF.
   - perf_clr together with a stall -> stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the RV32 pipeline. It keeps a small
// shift table of the NSTAGES instructions in flight beyond decode. Each entry
// holds valid, write-enable, is-load and destination register. From that
// table it derives:
//   - a per-operand forward select (the youngest matching entry wins),
//   - a decode stall on load-use hazards, which inserts a bubble into entry 1,
//   - a decode squash on redirect, which overrides the stall,
//   - a saturating count of stall cycles.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   dec_valid     in   decode holds a valid instruction
//   dec_rs        in   NSRC source register addresses, operand i at [i*REG_AW +: REG_AW]
//   dec_rs_used   in   operand i is actually read
//   dec_rd        in   destination register of the decode instruction
//   dec_we        in   decode instruction writes the register file
//   dec_is_load   in   decode instruction is a load
//   redirect      in   taken branch/jump resolved in entry 1 this cycle
//   perf_clr      in   synchronous clear of stall_cycles (wins over increment)
//   stall         out  hold PC and decode; bubble into entry 1
//   flush_dec     out  squash the decode instruction
//   fwd_sel       out  per operand: 0 = register file, k = forward from entry k
//   stage_valid   out  valid bit per entry (bit 0 = entry 1)
//   stall_cycles  out  saturating stall-cycle counter
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int NSTAGES  = 2,
    parameter int NSRC     = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int FSEL_W   = $clog2(NSTAGES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dec_valid,
    input  logic [NSRC*REG_AW-1:0]   dec_rs,
    input  logic [NSRC-1:0]          dec_rs_used,
    input  logic [REG_AW-1:0]        dec_rd,
    input  logic                     dec_we,
    input  logic                     dec_is_load,
    input  logic                     redirect,
    input  logic                     perf_clr,
    output logic                     stall,
    output logic                     flush_dec,
    output logic [NSRC*FSEL_W-1:0]   fwd_sel,
    output logic [NSTAGES-1:0]       stage_valid,
    output logic [31:0]              stall_cycles
);

    // Table storage: index j holds entry j+1 (index 0 = X, last = writeback side).
    logic [NSTAGES-1:0] valid_r;
    logic [NSTAGES-1:0] we_r;
    logic [NSTAGES-1:0] load_r;
    logic [REG_AW-1:0]  rd_r [NSTAGES];
    logic [31:0]        stall_cycles_r;

    logic [FSEL_W-1:0]  op_sel_s [NSRC];
    logic [NSRC-1:0]    op_lu_s;
    logic               stall_s;
    logic               flush_s;
    logic [NSRC*FSEL_W-1:0] fwd_sel_s;

    // An operand matches an entry only for a real read of a non-x0 register
    // that a valid, writing entry targets.
    function automatic logic entry_match(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic              ent_valid,
        input logic              ent_we,
        input logic [REG_AW-1:0] ent_rd
    );
        return used && (rs != '0) && ent_valid && ent_we && (ent_rd == rs);
    endfunction

    // Per-operand match search; scanning oldest to youngest lets the youngest
    // match overwrite, which gives smallest-k priority.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            op_sel_s[i] = '0;
            op_lu_s[i]  = 1'b0;
            for (int k = NSTAGES - 1; k >= 0; k--) begin
                if (entry_match(dec_rs_used[i], dec_rs[i*REG_AW +: REG_AW],
                                valid_r[k], we_r[k], rd_r[k])) begin
                    op_sel_s[i] = FSEL_W'(k + 1);
                    // A load still inside its latency window cannot forward yet.
                    op_lu_s[i]  = load_r[k] && ((k + 1) <= LOAD_LAT);
                end else begin
                    op_sel_s[i] = op_sel_s[i];
                    op_lu_s[i]  = op_lu_s[i];
                end
            end
        end
    end

    // Hazard outputs; everything is forced quiet while reset is held.
    always_comb begin
        fwd_sel_s = '0;
        stall_s   = 1'b0;
        flush_s   = 1'b0;
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                fwd_sel_s[i*FSEL_W +: FSEL_W] = op_sel_s[i];
            end
            // Redirect squashes decode, so a pending load-use no longer matters.
            stall_s = dec_valid && !redirect && (|op_lu_s);
            flush_s = redirect;
        end else begin
            fwd_sel_s = '0;
            stall_s   = 1'b0;
            flush_s   = 1'b0;
        end
    end

    // Table shift: entry 1 takes decode (or a bubble); older entries always advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
            we_r    <= '0;
            load_r  <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                rd_r[k] <= '0;
            end
        end else begin
            valid_r[0] <= dec_valid && !stall_s && !redirect;
            we_r[0]    <= dec_we;
            load_r[0]  <= dec_is_load;
            rd_r[0]    <= dec_rd;
            for (int k = 1; k < NSTAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                we_r[k]    <= we_r[k-1];
                load_r[k]  <= load_r[k-1];
                rd_r[k]    <= rd_r[k-1];
            end
        end
    end

    // Stall-cycle counter: clear wins over increment; increment saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= 32'd0;
        end else if (perf_clr) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall        = stall_s;
    assign flush_dec    = flush_s;
    assign fwd_sel      = fwd_sel_s;
    assign stage_valid  = valid_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for pipe_hazard_ctrl. The reference keeps a history queue of what was
// accepted each cycle (front = one cycle ago) and derives the outputs from the
// forwarding rules by searching that history by age.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int NSTAGES  = 2;
    localparam int NSRC     = 2;
    localparam int REG_AW   = 5;
    localparam int LOAD_LAT = 1;
    localparam int FSEL_W   = $clog2(NSTAGES + 1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   dec_valid;
    logic [NSRC*REG_AW-1:0] dec_rs;
    logic [NSRC-1:0]        dec_rs_used;
    logic [REG_AW-1:0]      dec_rd;
    logic                   dec_we;
    logic                   dec_is_load;
    logic                   redirect;
    logic                   perf_clr;
    logic                   stall;
    logic                   flush_dec;
    logic [NSRC*FSEL_W-1:0] fwd_sel;
    logic [NSTAGES-1:0]     stage_valid;
    logic [31:0]            stall_cycles;

    pipe_hazard_ctrl #(
        .NSTAGES(NSTAGES), .NSRC(NSRC), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rs_used(dec_rs_used), .dec_rd(dec_rd), .dec_we(dec_we),
        .dec_is_load(dec_is_load), .redirect(redirect), .perf_clr(perf_clr),
        .stall(stall), .flush_dec(flush_dec), .fwd_sel(fwd_sel),
        .stage_valid(stage_valid), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit                v;
        bit                we;
        bit                ld;
        logic [REG_AW-1:0] rd;
    } rec_t;

    rec_t        hist[$];
    logic [31:0] mcnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: search the history by age for the youngest writer of each source.
    function automatic void model_eval(output logic [NSRC*FSEL_W-1:0] sel, output logic stl);
        bit lu;
        lu  = 1'b0;
        sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            bit                found;
            logic [REG_AW-1:0] rs;
            found = 1'b0;
            rs    = dec_rs[i*REG_AW +: REG_AW];
            for (int a = 1; a <= hist.size(); a++) begin
                if (!found && dec_rs_used[i] && rs != 0 && hist[a-1].v &&
                    hist[a-1].we && hist[a-1].rd == rs) begin
                    found = 1'b1;
                    sel[i*FSEL_W +: FSEL_W] = FSEL_W'(a);
                    if (hist[a-1].ld && a <= LOAD_LAT) lu = 1'b1;
                end
            end
        end
        stl = dec_valid && !redirect && lu;
    endfunction

    // Reference state update at each rising edge.
    always @(posedge clk) begin
        logic [NSRC*FSEL_W-1:0] s;
        logic                   st;
        if (!reset) begin
            hist.delete();
            mcnt = 32'd0;
        end else begin
            model_eval(s, st);
            hist.push_front('{dec_valid && !st && !redirect, dec_we, dec_is_load, dec_rd});
            if (hist.size() > NSTAGES) void'(hist.pop_back());
            if (perf_clr) mcnt = 32'd0;
            else if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        logic [NSRC*FSEL_W-1:0] es;
        logic                   est;
        logic [NSTAGES-1:0]     esv;
        if (!reset) begin
            check("rst_stall", {31'd0, stall}, 32'd0);
            check("rst_flush", {31'd0, flush_dec}, 32'd0);
            check("rst_fwd", 32'(fwd_sel), 32'd0);
            check("rst_sv", 32'(stage_valid), 32'd0);
            check("rst_cnt", stall_cycles, 32'd0);
        end else begin
            model_eval(es, est);
            esv = '0;
            for (int a = 1; a <= NSTAGES; a++) begin
                if (a <= hist.size()) esv[a-1] = hist[a-1].v;
            end
            check("stall", {31'd0, stall}, {31'd0, est});
            check("flush", {31'd0, flush_dec}, {31'd0, redirect});
            for (int i = 0; i < NSRC; i++) begin
                check("fwd_sel", 32'(fwd_sel[i*FSEL_W +: FSEL_W]), 32'(es[i*FSEL_W +: FSEL_W]));
            end
            check("stage_valid", 32'(stage_valid), 32'(esv));
            check("stall_cycles", stall_cycles, mcnt);
        end
    end

    task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] used, input logic [4:0] rd, input bit we,
                        input bit ld, input bit redir, input bit clr);
        @(posedge clk);
        #1;
        dec_valid   = v;
        dec_rs      = {rs2, rs1};
        dec_rs_used = used;
        dec_rd      = rd;
        dec_we      = we;
        dec_is_load = ld;
        redirect    = redir;
        perf_clr    = clr;
    endtask

    function automatic logic [31:0] sel_of(input int i);
        return 32'(fwd_sel[i*FSEL_W +: FSEL_W]);
    endfunction

    initial begin
        reset = 1'b0; dec_valid = 1'b0; dec_rs = '0; dec_rs_used = '0; dec_rd = '0;
        dec_we = 1'b0; dec_is_load = 1'b0; redirect = 1'b0; perf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Forward distance
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        step(1, 5, 0, 2'b01, 9, 0, 0, 0, 0);
        @(negedge clk); check("t1_fwd_k1", sel_of(0), 32'd1); check("t1_nostall", {31'd0, stall}, 32'd0);
        step(1, 5, 0, 2'b01, 9, 0, 0, 0, 0);
        @(negedge clk); check("t1_fwd_k2", sel_of(0), 32'd2);
        step(1, 5, 0, 2'b01, 9, 0, 0, 0, 0);
        @(negedge clk); check("t1_fwd_rf", sel_of(0), 32'd0);

        // Load-use, with counter cleared as the load is accepted
        step(1, 0, 0, 2'b00, 6, 1, 1, 0, 1);
        step(1, 6, 6, 2'b11, 7, 1, 0, 0, 0);
        @(negedge clk); check("t2_stall", {31'd0, stall}, 32'd1);
        step(1, 6, 6, 2'b11, 7, 1, 0, 0, 0);
        @(negedge clk);
        check("t2_bubble", {31'd0, stage_valid[0]}, 32'd0);
        check("t2_release", {31'd0, stall}, 32'd0);
        check("t2_fwd", 32'(fwd_sel), 32'h0000_000A);
        check("t2_cnt", stall_cycles, 32'd1);

        // Youngest wins; unused operand never forwards
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        step(1, 5, 5, 2'b01, 8, 0, 0, 0, 0);
        @(negedge clk); check("t3_young", sel_of(0), 32'd1); check("t3_unused", sel_of(1), 32'd0);

        // x0 writer never matches
        step(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        step(1, 0, 0, 2'b11, 8, 0, 0, 0, 0);
        @(negedge clk); check("t4_fwd", 32'(fwd_sel), 32'd0); check("t4_stall", {31'd0, stall}, 32'd0);

        // Redirect overrides a load-use stall
        step(1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        step(1, 6, 6, 2'b11, 7, 1, 0, 1, 0);
        @(negedge clk); check("t5_stall", {31'd0, stall}, 32'd0); check("t5_flush", {31'd0, flush_dec}, 32'd1);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); check("t5_bubble", {31'd0, stage_valid[0]}, 32'd0); check("t5_cnt", stall_cycles, 32'd1);

        // Asynchronous reset between edges with a full table
        step(1, 0, 0, 2'b00, 1, 1, 0, 0, 0);
        step(1, 0, 0, 2'b00, 2, 1, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("t6_rst_sv", 32'(stage_valid), 32'd0);
        check("t6_rst_cnt", stall_cycles, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; dec_valid = 1'b0;

        // Saturation: preload the counter at all-ones, then stall
        @(posedge clk);
        #1;
        force dut.stall_cycles_r = 32'hFFFF_FFFF;
        mcnt = 32'hFFFF_FFFF;
        #1 release dut.stall_cycles_r;
        step(1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        step(1, 6, 0, 2'b01, 7, 1, 0, 0, 0);
        @(negedge clk); check("t6_sat_stall", {31'd0, stall}, 32'd1);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); check("t6_sat", stall_cycles, 32'hFFFF_FFFF);

        // Clear wins over a simultaneous stall
        step(1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
        step(1, 0, 6, 2'b10, 7, 1, 0, 0, 1);
        @(negedge clk); check("t6_clr_stall", {31'd0, stall}, 32'd1);
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge clk); check("t6_clr", stall_cycles, 32'd0);

        // Randomised traffic over a small register set to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset       = ($urandom_range(0, 199) != 0);
            dec_valid   = ($urandom_range(0, 9) != 0);
            dec_rs      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            dec_rs_used = 2'($urandom_range(0, 3));
            dec_rd      = 5'($urandom_range(0, 3));
            dec_we      = ($urandom_range(0, 3) != 0);
            dec_is_load = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            perf_clr    = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
